cpu_test_harness_ctrl: RTL and testbench

Parametrised run controller for processor bring-up and regression. It sequences core reset and snoops each hart's data-memory write port for a tohost pass/fail report. It also counts cycles and retired instructions, and ends the run on completion, failure or watchdog timeout. It sits between the top-level clock/reset and one or more processor cores (in-order or out-of-order). It replaces fixed-delay reset/finish sequencing with a reusable, observable block usable in simulation and on FPGA.

---
 rtl/cpu_test_harness_ctrl.sv | 143 ++++++++++++++
 tb/tb_cpu_test_harness_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_test_harness_ctrl.sv
// Run controller for processor bring-up: sequences core reset, snoops each hart's
// tohost writes for pass/fail reports, counts cycles/retires and ends the run.
module cpu_test_harness_ctrl #(
    parameter int                NUM_HARTS      = 2,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000),
    parameter int                RESET_CYCLES   = 2,
    parameter int                TIMEOUT_CYCLES = 100,
    parameter bit                STOP_ON_FAIL   = 1'b1,
    localparam int               FH_W           = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        restart,
    input  logic [NUM_HARTS-1:0]        ret_valid,
    input  logic [NUM_HARTS-1:0]        mem_we,
    input  logic [NUM_HARTS*ADDR_W-1:0] mem_addr,
    input  logic [NUM_HARTS*DATA_W-1:0] mem_wdata,
    output logic                        core_rst_n,
    output logic                        running,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [NUM_HARTS-1:0]        hart_done,
    output logic [FH_W-1:0]             fail_hart,
    output logic [DATA_W-2:0]           fail_code,
    output logic [31:0]                 cycle_count,
    output logic [NUM_HARTS*32-1:0]     retire_count
);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [31:0]                 hold_q, hold_d;
    logic [31:0]                 cycle_q, cycle_d;
    logic [NUM_HARTS-1:0][31:0]  retire_q, retire_d;
    logic [NUM_HARTS-1:0]        hart_done_q, hart_done_d;
    logic                        fail_q, fail_d;
    logic [FH_W-1:0]             fail_hart_q, fail_hart_d;
    logic [DATA_W-2:0]           fail_code_q, fail_code_d;
    logic                        timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cycle_d     = cycle_q;
        retire_d    = retire_q;
        hart_done_d = hart_done_q;
        fail_d      = fail_q;
        fail_hart_d = fail_hart_q;
        fail_code_d = fail_code_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_q == 32'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            ST_RUN: begin
                cycle_d = cycle_q + 32'd1;
                // Ascending scan with fail_d as the guard keeps only the lowest-index first failure.
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (ret_valid[h] && !hart_done_q[h] && (retire_q[h] != 32'hFFFF_FFFF))
                        retire_d[h] = retire_q[h] + 32'd1;
                    if (!hart_done_q[h] && mem_we[h] &&
                        (mem_addr[h*ADDR_W +: ADDR_W] == TOHOST_ADDR)) begin
                        hart_done_d[h] = 1'b1;
                        if ((mem_wdata[h*DATA_W +: DATA_W] != DATA_W'(1)) && !fail_d) begin
                            fail_d      = 1'b1;
                            fail_hart_d = FH_W'(h);
                            fail_code_d = mem_wdata[h*DATA_W+1 +: DATA_W-1];
                        end
                    end
                end
                // A report that ends the run takes priority over the watchdog.
                if ((&hart_done_d) || (fail_d && STOP_ON_FAIL)) begin
                    state_d = ST_DONE;
                end else if (cycle_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_d     = ST_HOLD;
                    hold_d      = '0;
                    cycle_d     = '0;
                    retire_d    = '0;
                    hart_done_d = '0;
                    fail_d      = 1'b0;
                    fail_hart_d = '0;
                    fail_code_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HOLD;
            hold_q      <= '0;
            cycle_q     <= '0;
            retire_q    <= '0;
            hart_done_q <= '0;
            fail_q      <= 1'b0;
            fail_hart_q <= '0;
            fail_code_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cycle_q     <= cycle_d;
            retire_q    <= retire_d;
            hart_done_q <= hart_done_d;
            fail_q      <= fail_d;
            fail_hart_q <= fail_hart_d;
            fail_code_q <= fail_code_d;
            timeout_q   <= timeout_d;
        end
    end

    assign core_rst_n   = (state_q != ST_HOLD);
    assign running      = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign pass         = done && !fail_q && (&hart_done_q);
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign hart_done    = hart_done_q;
    assign fail_hart    = fail_hart_q;
    assign fail_code    = fail_code_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_cpu_test_harness_ctrl.sv
// Scoreboard bench for cpu_test_harness_ctrl: directed runs push expected end-of-run
// status; a monitor pops and compares on each rising edge of done.
module tb_cpu_test_harness_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic [1:0]  ret_valid;
    logic [1:0]  mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        core_rst_n, running, done, pass, fail, timeout;
    logic [1:0]  hart_done;
    logic [0:0]  fail_hart;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic [63:0] retire_count;

    cpu_test_harness_ctrl dut (
        .clk(clk), .reset(reset), .restart(restart), .ret_valid(ret_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst_n(core_rst_n), .running(running), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .hart_done(hart_done), .fail_hart(fail_hart),
        .fail_code(fail_code), .cycle_count(cycle_count), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pass, fail, timeout;
        logic [0:0]  fhart;
        logic [30:0] fcode;
        logic [31:0] cyc;
        logic [1:0]  hd;
        logic [31:0] r0, r1;
    } exp_t;

    typedef struct {
        int          cyc;
        int          hart;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    exp_t scq[$];
    ev_t  evq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: each completed run is one scoreboard transaction.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (scq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = scq.pop_front();
                chk("pass",      32'(pass),                e.pass);
                chk("fail",      32'(fail),                e.fail);
                chk("timeout",   32'(timeout),             e.timeout);
                chk("fail_hart", 32'(fail_hart),           32'(e.fhart));
                chk("fail_code", 32'(fail_code),           32'(e.fcode));
                chk("cycles",    cycle_count,              e.cyc);
                chk("hart_done", 32'(hart_done),           32'(e.hd));
                chk("retire0",   retire_count[31:0],       e.r0);
                chk("retire1",   retire_count[63:32],      e.r1);
                chk("running_dropped", 32'(running),       32'd0);
                chk("core_rst_n_done", 32'(core_rst_n),    32'd1);
            end
        end
        done_prev <= done;
    end

    task automatic chk_cleared(input string tag);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_running"},    32'(running),    32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_fail"},       32'(fail),       32'd0);
        chk({tag, "_hart_done"},  32'(hart_done),  32'd0);
        chk({tag, "_cycles"},     cycle_count,     32'd0);
        chk({tag, "_retire0"},    retire_count[31:0],  32'd0);
        chk({tag, "_retire1"},    retire_count[63:32], 32'd0);
    endtask

    // Called at a negedge with reset low; releases it and checks the two-cycle hold.
    task automatic release_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("hold_edge1_core_rst_n", 32'(core_rst_n), 32'd0);
        @(negedge clk);
        chk("hold_edge2_core_rst_n", 32'(core_rst_n), 32'd1);
        chk("hold_edge2_running",    32'(running),    32'd1);
    endtask

    task automatic wait_run_start();
        for (int i = 0; i < 20 && !running; i++) @(negedge clk);
        if (!running) chk("run_start_timeout", 32'd0, 32'd1);
    endtask

    // Drives queued tohost writes at the given RUN cycle indices (cycle 0 = first RUN cycle).
    task automatic drive_events(input int last_cyc);
        for (int c = 0; c <= last_cyc; c++) begin
            mem_we = '0;
            foreach (evq[k]) begin
                if (evq[k].cyc == c) begin
                    mem_we[evq[k].hart]                 = 1'b1;
                    mem_addr[evq[k].hart*32 +: 32]      = evq[k].addr;
                    mem_wdata[evq[k].hart*32 +: 32]     = evq[k].data;
                end
            end
            @(negedge clk);
        end
        mem_we = '0;
        evq.delete();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic push(input logic p, input logic f, input logic t, input logic [0:0] fh,
                        input logic [30:0] fc, input logic [31:0] cyc, input logic [1:0] hd,
                        input logic [31:0] r0, input logic [31:0] r1);
        exp_t e;
        e.pass = p; e.fail = f; e.timeout = t; e.fhart = fh; e.fcode = fc;
        e.cyc = cyc; e.hd = hd; e.r0 = r0; e.r1 = r1;
        scq.push_back(e);
    endtask

    task automatic add_ev(input int c, input int h, input logic [31:0] a, input logic [31:0] d);
        ev_t ev;
        ev.cyc = c; ev.hart = h; ev.addr = a; ev.data = d;
        evq.push_back(ev);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish required finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b0; restart = 1'b0; ret_valid = 2'b11;
        mem_we = '0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(negedge clk);
        chk_cleared("por");
        chk("por_timeout", 32'(timeout), 32'd0);
        chk("por_pass",    32'(pass),    32'd0);
        release_reset();

        // Both harts pass; a non-tohost write is ignored.
        push(1, 0, 0, 0, 0, 21, 2'b11, 11, 21);
        add_ev(2, 0, 32'h1004, 32'h3);
        add_ev(10, 0, 32'h1000, 32'h1);
        add_ev(20, 1, 32'h1000, 32'h1);
        drive_events(20);
        wait_done(10);
        do_restart();
        chk_cleared("restart1");

        // Hart 1 fails with code 3; run stops and hart 0's retire count freezes.
        wait_run_start();
        push(0, 1, 0, 1, 3, 6, 2'b10, 6, 6);
        add_ev(5, 1, 32'h1000, 32'h7);
        drive_events(5);
        wait_done(10);
        repeat (3) @(negedge clk);
        chk("frozen_retire0", retire_count[31:0], 32'd6);
        chk("frozen_cycles",  cycle_count,        32'd6);
        do_restart();

        // Same-cycle failures: lowest index wins.
        wait_run_start();
        push(0, 1, 0, 0, 2, 4, 2'b11, 4, 4);
        add_ev(3, 0, 32'h1000, 32'h5);
        add_ev(3, 1, 32'h1000, 32'h9);
        drive_events(3);
        wait_done(10);
        do_restart();

        // No reports: watchdog fires after 100 RUN cycles.
        wait_run_start();
        push(0, 0, 1, 0, 0, 100, 2'b00, 100, 100);
        wait_done(150);
        do_restart();

        // Final pass lands in the watchdog cycle; a repeat report from hart 0 is ignored.
        wait_run_start();
        push(1, 0, 0, 0, 0, 100, 2'b11, 51, 100);
        add_ev(50, 0, 32'h1000, 32'h1);
        add_ev(60, 0, 32'h1000, 32'h3);
        add_ev(99, 1, 32'h1000, 32'h1);
        drive_events(99);
        wait_done(10);
        do_restart();

        // Reset dropped mid-RUN clears everything without a clock edge.
        wait_run_start();
        drive_events(29);
        chk("pre_reset_cycles", cycle_count, 32'd30);
        #2 reset = 1'b0;
        #1 chk_cleared("async_reset");
        @(negedge clk);
        release_reset();

        // Value 0 is a fail with code 0; then restart clears status and counters.
        push(0, 1, 0, 1, 0, 5, 2'b11, 3, 5);
        add_ev(2, 0, 32'h1000, 32'h1);
        add_ev(4, 1, 32'h1000, 32'h0);
        drive_events(4);
        wait_done(10);
        do_restart();
        chk_cleared("restart_final");
        chk("restart_final_timeout", 32'(timeout), 32'd0);

        if (scq.size() != 0) chk("scoreboard_leftover", scq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
